multdiv_unit: RTL and testbench

Iterative signed 32-bit multiply/divide unit in the execute stage. It sits directly downstream of the opcode decoder and starts when the decoder flags an ALU-type mult or div instruction. It latches both operands on a one-cycle start pulse and produces a result with a ready pulse after a fixed latency. The pipeline control stalls on busy and writes back on data_resultRDY.

---
 rtl/multdiv_unit.sv | 230 +++++++++++++++++++++++
 tb/tb_multdiv_unit.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_unit.sv
// -----------------------------------------------------------------------------
// multdiv_unit
//
// Iterative signed multiply / divide unit for the execute stage. A one-cycle
// start pulse latches both operands. ITER iteration edges follow, then one
// DONE cycle. The result is then presented together with a one-cycle ready
// pulse. Total latency from the start edge to the edge that raises the ready
// pulse is ITER + 1 edges.
//
// Multiply: signed shift-add on a 64-bit accumulator. The MSB of the
//           multiplier carries weight -2^(DATA_W-1), so the last step
//           subtracts instead of adding.
// Divide:   unsigned restoring division on operand magnitudes, one quotient
//           bit per edge. The sign is applied when the result is selected.
//
// Ports:
//   clock           system clock, rising edge
//   reset           asynchronous, active-high reset
//   ctrl_MULT       one-cycle start pulse, signed multiply (wins over ctrl_DIV)
//   ctrl_DIV        one-cycle start pulse, signed divide
//   data_operandA   multiplicand / dividend, sampled on the start edge only
//   data_operandB   multiplier / divisor, sampled on the start edge only
//   data_result     low half of product, or quotient (held until next DONE)
//   data_exception  overflow or divide-by-zero flag of the last completed op
//   data_resultRDY  one-cycle pulse, data_result / data_exception valid
//   busy            high while an operation is in flight
// -----------------------------------------------------------------------------
module multdiv_unit #(
    parameter int DATA_W = 32,
    parameter int ITER   = DATA_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              ctrl_MULT,
    input  logic              ctrl_DIV,
    input  logic [DATA_W-1:0] data_operandA,
    input  logic [DATA_W-1:0] data_operandB,
    output logic [DATA_W-1:0] data_result,
    output logic              data_exception,
    output logic              data_resultRDY,
    output logic              busy
);

    localparam int PROD_W = 2 * DATA_W;
    localparam int CNT_W  = $clog2(ITER);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t state, state_next;

    // Operation context latched on the start edge.
    logic [CNT_W-1:0]  cnt;
    logic              op_mul;
    logic              neg_q;
    logic              div_zero;

    // Multiply datapath.
    logic [PROD_W-1:0] mcand;      // sign-extended multiplicand, shifted left per step
    logic [DATA_W-1:0] mplier;     // multiplier, shifted right per step
    logic [PROD_W-1:0] prod;

    // Divide datapath. The dividend magnitude starts in quo and shifts out of
    // the top while quotient bits shift in at the bottom.
    logic [DATA_W:0]   rem;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] divisor;

    // Combinational helpers.
    logic              start;
    logic              last_iter;
    logic              done_fire;
    logic [PROD_W-1:0] mul_addend;
    logic [PROD_W-1:0] prod_step;
    logic [DATA_W+1:0] rem_shift;
    logic [DATA_W+1:0] rem_diff;
    logic              sub_ok;
    logic [DATA_W:0]   rem_next;
    logic [DATA_W:0]   prod_top;
    logic              mul_ovf;
    logic [DATA_W-1:0] quo_signed;
    logic              div_ovf;
    logic [DATA_W-1:0] final_result;
    logic              final_exc;

    function automatic logic [DATA_W-1:0] magnitude(input logic [DATA_W-1:0] v);
        // The most negative value maps onto itself, which is also its correct
        // unsigned magnitude.
        return v[DATA_W-1] ? (~v + DATA_W'(1)) : v;
    endfunction

    assign start     = ctrl_MULT | ctrl_DIV;
    assign last_iter = (cnt == CNT_W'(ITER - 1));

    // -------------------------------------------------------------------------
    // FSM: state register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // -------------------------------------------------------------------------
    // FSM: next-state logic. A start in any state (re)launches an operation.
    // -------------------------------------------------------------------------
    // NOTE: state_next gets a default before any branch so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        if (start) begin
            state_next = ctrl_MULT ? MUL : DIV;
        end else begin
            case (state)
                IDLE:    state_next = IDLE;
                MUL,
                DIV:     if (last_iter) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // -------------------------------------------------------------------------
    // FSM: outputs decoded from state
    // -------------------------------------------------------------------------
    always_comb begin
        busy      = (state != IDLE);
        // A start on the DONE edge aborts the finishing op, so it publishes nothing.
        done_fire = (state == DONE) && !start;
    end

    // -------------------------------------------------------------------------
    // Datapath combinational steps
    // -------------------------------------------------------------------------
    always_comb begin
        // Multiply step: the last step has negative weight.
        mul_addend = mplier[0] ? mcand : '0;
        prod_step  = last_iter ? (prod - mul_addend) : (prod + mul_addend);

        // Restoring-division step.
        rem_shift  = {rem, quo[DATA_W-1]};
        rem_diff   = rem_shift - {2'b00, divisor};
        sub_ok     = ~rem_diff[DATA_W+1];
        rem_next   = sub_ok ? rem_diff[DATA_W:0] : rem_shift[DATA_W:0];

        // Product overflows when the upper half plus bit DATA_W-1 are not all equal.
        prod_top   = prod[PROD_W-1:DATA_W-1];
        mul_ovf    = ~((&prod_top) | ~(|prod_top));

        // A positive quotient with the top bit set only arises from MIN / -1.
        quo_signed = neg_q ? (~quo + DATA_W'(1)) : quo;
        div_ovf    = ~neg_q & quo[DATA_W-1];

        if (op_mul) begin
            final_result = prod[DATA_W-1:0];
            final_exc    = mul_ovf;
        end else if (div_zero) begin
            final_result = '0;
            final_exc    = 1'b1;
        end else begin
            final_result = quo_signed;
            final_exc    = div_ovf;
        end
    end

    // -------------------------------------------------------------------------
    // Datapath registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            op_mul   <= 1'b0;
            neg_q    <= 1'b0;
            div_zero <= 1'b0;
            mcand    <= '0;
            mplier   <= '0;
            prod     <= '0;
            rem      <= '0;
            quo      <= '0;
            divisor  <= '0;
        end else if (start) begin
            cnt      <= '0;
            op_mul   <= ctrl_MULT;
            neg_q    <= data_operandA[DATA_W-1] ^ data_operandB[DATA_W-1];
            div_zero <= (data_operandB == '0);
            mcand    <= {{DATA_W{data_operandA[DATA_W-1]}}, data_operandA};
            mplier   <= data_operandB;
            prod     <= '0;
            rem      <= '0;
            quo      <= magnitude(data_operandA);
            divisor  <= magnitude(data_operandB);
        end else if (state == MUL) begin
            cnt    <= cnt + CNT_W'(1);
            prod   <= prod_step;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
        end else if (state == DIV) begin
            cnt <= cnt + CNT_W'(1);
            rem <= rem_next;
            quo <= {quo[DATA_W-2:0], sub_ok};
        end
    end

    // -------------------------------------------------------------------------
    // Result registers: updated only when an op completes, held otherwise.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            data_result    <= '0;
            data_exception <= 1'b0;
            data_resultRDY <= 1'b0;
        end else begin
            data_resultRDY <= done_fire;
            if (done_fire) begin
                data_result    <= final_result;
                data_exception <= final_exc;
            end
        end
    end

endmodule

// File: tb/tb_multdiv_unit.sv
// -----------------------------------------------------------------------------
// tb_multdiv_unit
//
// Directed testbench for multdiv_unit. Inputs are driven and outputs sampled
// on the falling clock edge. "Edge k" is the k-th rising edge after the start
// edge (edge 0).
// -----------------------------------------------------------------------------
module tb_multdiv_unit;

    logic        clock;
    logic        reset;
    logic        ctrl_MULT;
    logic        ctrl_DIV;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [31:0] data_result;
    logic        data_exception;
    logic        data_resultRDY;
    logic        busy;

    int total = 0;
    int bad   = 0;

    // Last published result, tracked to check output hold.
    logic [31:0] prev_res = 32'h0;
    logic        prev_exc = 1'b0;

    multdiv_unit dut (
        .clock          (clock),
        .reset          (reset),
        .ctrl_MULT      (ctrl_MULT),
        .ctrl_DIV       (ctrl_DIV),
        .data_operandA  (a_in),
        .data_operandB  (b_in),
        .data_result    (data_result),
        .data_exception (data_exception),
        .data_resultRDY (data_resultRDY),
        .busy           (busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Pulse a start for one cycle; on return the start edge has passed.
    // Operands are scrambled afterwards to show they are not re-sampled.
    task automatic issue(input logic m, input logic d,
                         input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        ctrl_MULT = m;
        ctrl_DIV  = d;
        a_in      = a;
        b_in      = b;
        @(negedge clock);
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        a_in      = $urandom;
        b_in      = $urandom;
    endtask

    // Walk edges 1..34 after a start and check RDY timing, busy, output hold
    // and the final result.
    task automatic observe(input logic [31:0] er, input logic ee, input string nm);
        logic exp_rdy;
        logic exp_busy;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clock);
            exp_rdy  = (k == 33);
            exp_busy = (k < 33);
            total++;
            if (data_resultRDY !== exp_rdy) begin
                bad++;
                $display("FAIL %s rdy edge %0d: got %b want %b", nm, k, data_resultRDY, exp_rdy);
            end
            total++;
            if (busy !== exp_busy) begin
                bad++;
                $display("FAIL %s busy edge %0d: got %b want %b", nm, k, busy, exp_busy);
            end
            if (k < 33) begin
                total++;
                if (data_result !== prev_res || data_exception !== prev_exc) begin
                    bad++;
                    $display("FAIL %s hold edge %0d: got %h/%b want %h/%b",
                             nm, k, data_result, data_exception, prev_res, prev_exc);
                end
            end else begin
                total++;
                if (data_result !== er || data_exception !== ee) begin
                    bad++;
                    $display("FAIL %s result edge %0d: got %h/%b want %h/%b",
                             nm, k, data_result, data_exception, er, ee);
                end
            end
        end
        prev_res = er;
        prev_exc = ee;
    endtask

    task automatic test_reset();
        reset     = 1'b1;
        ctrl_MULT = 1'b0;
        ctrl_DIV  = 1'b0;
        a_in      = 32'h0;
        b_in      = 32'h0;
        @(negedge clock);
        @(negedge clock);
        total++;
        if (data_result !== 32'h0 || data_exception !== 1'b0 ||
            data_resultRDY !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: got res=%h exc=%b rdy=%b busy=%b want 0",
                     data_result, data_exception, data_resultRDY, busy);
        end
        reset = 1'b0;
        @(negedge clock);
        total++;
        if (data_resultRDY !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: got rdy=%b busy=%b want 0", data_resultRDY, busy);
        end
    endtask

    task automatic test_mult();
        issue(1'b1, 1'b0, 32'd7, 32'hFFFF_FFFA);
        observe(32'hFFFF_FFD6, 1'b0, "mul_7_m6");
        issue(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
        observe(32'h0000_0000, 1'b1, "mul_ovf");
        issue(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        observe(32'h0000_0001, 1'b0, "mul_m1_m1");
    endtask

    task automatic test_div();
        issue(1'b0, 1'b1, 32'hFFFF_FF9C, 32'd7);
        observe(32'hFFFF_FFF2, 1'b0, "div_m100_7");
        issue(1'b0, 1'b1, 32'd100, 32'hFFFF_FFF9);
        observe(32'hFFFF_FFF2, 1'b0, "div_100_m7");
        issue(1'b0, 1'b1, 32'd0, 32'd9);
        observe(32'h0000_0000, 1'b0, "div_zero_dividend");
    endtask

    task automatic test_div_corner();
        issue(1'b0, 1'b1, 32'd5, 32'd0);
        observe(32'h0000_0000, 1'b1, "div_by_zero");
        issue(1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
        observe(32'h8000_0000, 1'b1, "div_min_m1");
    endtask

    // Multiply aborted by a divide start at edge 10.
    task automatic test_back_to_back();
        issue(1'b1, 1'b0, 32'd3, 32'd4);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            total++;
            if (data_resultRDY !== 1'b0 || busy !== 1'b1) begin
                bad++;
                $display("FAIL restart_pre edge %0d: got rdy=%b busy=%b want 0/1",
                         k, data_resultRDY, busy);
            end
        end
        issue(1'b0, 1'b1, 32'd20, 32'd4);
        observe(32'd5, 1'b0, "restart_div");
    endtask

    task automatic test_async_reset();
        issue(1'b0, 1'b1, 32'd100, 32'd3);
        for (int k = 1; k <= 14; k++) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        total++;
        if (data_result !== 32'h0 || data_exception !== 1'b0 ||
            data_resultRDY !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL async_reset: got res=%h exc=%b rdy=%b busy=%b want 0",
                     data_result, data_exception, data_resultRDY, busy);
        end
        @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k < 36; k++) begin
            @(negedge clock);
            total++;
            if (data_resultRDY !== 1'b0 || busy !== 1'b0 || data_result !== 32'h0) begin
                bad++;
                $display("FAIL post_reset cycle %0d: got rdy=%b busy=%b res=%h want 0",
                         k, data_resultRDY, busy, data_result);
            end
        end
        prev_res = 32'h0;
        prev_exc = 1'b0;
        issue(1'b1, 1'b0, 32'd2, 32'd3);
        observe(32'd6, 1'b0, "mul_after_reset");
        issue(1'b1, 1'b1, 32'd6, 32'd3);
        observe(32'd18, 1'b0, "both_starts_mult");
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_corner();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
